// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I memory-port arbiter: FSM states, owner IDs
// and the round-robin pick used at arbitration time.
package rv32i_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] WAIT = 2'b10;

  localparam logic OWNER_IFETCH = 1'b0;
  localparam logic OWNER_DATA   = 1'b1;

  // A lone requester wins; on a tie the requester that did not go last wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_owner);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_owner;
    end else if (req1) begin
      pick = OWNER_DATA;
    end else begin
      pick = OWNER_IFETCH;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux2to1_rv32i.sv
// Generic two-input multiplexer used for the memory-port payload paths.
module mux2to1_rv32i #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mem_arbiter_rv32i.sv
// Round-robin arbiter/sequencer sharing one memory port between instruction
// fetch (requester 0) and load/store (requester 1), with response timeout.
module mem_arbiter_rv32i
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    r0_req,
  input  logic [ADDR_WIDTH-1:0]   r0_addr,
  output logic                    r0_ack,
  output logic                    r0_rvalid,
  output logic                    r0_err,
  output logic [DATA_WIDTH-1:0]   r0_rdata,
  input  logic                    r1_req,
  input  logic                    r1_we,
  input  logic [ADDR_WIDTH-1:0]   r1_addr,
  input  logic [DATA_WIDTH-1:0]   r1_wdata,
  input  logic [DATA_WIDTH/8-1:0] r1_wstrb,
  output logic                    r1_ack,
  output logic                    r1_rvalid,
  output logic                    r1_err,
  output logic [DATA_WIDTH-1:0]   r1_rdata,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_gnt,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    sel
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = $clog2(WAIT_LIMIT + 1);
  // Last cycle (counted from REQ entry as 0) in which a response is still accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_ABORT = CNT_WIDTH'(WAIT_LIMIT - 1);

  logic [1:0]            r_state;
  logic                  r_owner;
  logic                  r_last_owner;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [1:0]            w_state_nxt;
  logic                  w_owner_nxt;
  logic                  w_last_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;

  logic                  w_in_req;
  logic                  w_in_wait;
  logic                  w_active;
  logic                  w_grant;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_abort;
  logic [ADDR_WIDTH-1:0] w_addr_mux;
  logic [DATA_WIDTH-1:0] w_wdata_mux;
  logic [STRB_WIDTH-1:0] w_wstrb_mux;

  assign w_in_req  = (r_state == REQ);
  assign w_in_wait = (r_state == WAIT);
  assign w_active  = (r_state != IDLE);
  assign w_grant   = w_in_req & m_gnt;
  assign w_done    = w_in_wait & m_rvalid;
  assign w_timeout = (r_cnt >= CNT_ABORT);
  // A grant or completion in the final cycle beats the timeout.
  assign w_abort   = ((w_in_req & ~m_gnt) | (w_in_wait & ~m_rvalid)) & w_timeout;

  // State, ownership and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= OWNER_IFETCH;
      r_last_owner <= OWNER_DATA;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // Next-state logic; the counter only advances when the transaction stays open.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r0_req || r1_req) begin
          w_owner_nxt = rr_pick(r0_req, r1_req, r_last_owner);
          w_cnt_nxt   = '0;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (w_grant) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
        end else if (w_abort) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
        end
      end
      WAIT: begin
        if (w_done || w_abort) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_owner;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  mux2to1_rv32i #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
    .i_sel (r_owner),
    .i_d0  (r0_addr),
    .i_d1  (r1_addr),
    .o_y   (w_addr_mux)
  );

  // Fetch has no write data or strobes, so its mux leg is tied to zero.
  mux2to1_rv32i #(.WIDTH(DATA_WIDTH)) u_wdata_mux (
    .i_sel (r_owner),
    .i_d0  ({DATA_WIDTH{1'b0}}),
    .i_d1  (r1_wdata),
    .o_y   (w_wdata_mux)
  );

  mux2to1_rv32i #(.WIDTH(STRB_WIDTH)) u_wstrb_mux (
    .i_sel (r_owner),
    .i_d0  ({STRB_WIDTH{1'b0}}),
    .i_d1  (r1_wstrb),
    .o_y   (w_wstrb_mux)
  );

  assign sel     = r_owner;
  assign m_req   = w_in_req;
  assign m_we    = w_in_req & (r_owner == OWNER_DATA) & r1_we;
  assign m_addr  = w_active ? w_addr_mux : '0;
  assign m_wdata = w_active ? w_wdata_mux : '0;
  assign m_wstrb = w_in_req ? w_wstrb_mux : '0;

  // Handshakes and read data are routed to the owner only.
  assign r0_ack    = w_grant & (r_owner == OWNER_IFETCH);
  assign r1_ack    = w_grant & (r_owner == OWNER_DATA);
  assign r0_rvalid = w_done  & (r_owner == OWNER_IFETCH);
  assign r1_rvalid = w_done  & (r_owner == OWNER_DATA);
  assign r0_err    = w_abort & (r_owner == OWNER_IFETCH);
  assign r1_err    = w_abort & (r_owner == OWNER_DATA);
  assign r0_rdata  = r0_rvalid ? m_rdata : '0;
  assign r1_rdata  = r1_rvalid ? m_rdata : '0;

endmodule
